// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings and lane helpers for the data-memory controller.
// Lane = byte position within the 32-bit word; size codes match the request port.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic is_unsigned);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: res = is_unsigned ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: res = is_unsigned ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SZ_WORD: res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between a MEM-stage master and the data-memory controller.
// Requests use valid/ready; responses are a one-cycle pulse with no backpressure.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl_array.sv
// dmem_array: DEPTH_WORDS x 32 storage, byte-enable write at the clock edge, combinational read.
// Contents are not reset; they start at zero.
module dmem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [3:0]       wr_be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wr_dat,
  output logic [31:0]      rd_dat
);
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[addr][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  assign rd_dat = mem[addr];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed RAM, commit LATENCY edges after accept, req_ready low while BUSY.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of force-aligning them.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1,
  parameter int ADDR_W      = 32
) (
  input  logic       clk,
  input  logic       rst,
  dmem_ctrl_if.slave bus
);
  localparam int              IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]      CNT_INIT   = 4'(LATENCY - 1);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH_WORDS * 4);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              misalign, acc_err, commit, wr_en;
  logic [1:0]        lane;
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       rd_word, wr_word;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((size_q == SZ_HALF) && addr_q[0]) ||
                    ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign acc_err = (size_q == 2'b11) || ({1'b0, addr_q} >= ADDR_LIMIT) || misalign;

  // Low address bits beyond the access size are ignored, which force-aligns when the check is off.
  always_comb begin
    case (size_q)
      SZ_BYTE: lane = addr_q[1:0];
      SZ_HALF: lane = {addr_q[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  assign word_idx = addr_q[IDX_W+1:2];
  assign commit   = (state_q == S_BUSY) && (cnt_q == 4'd0);
  assign wr_en    = commit && we_q && !acc_err;
  assign wr_word  = wdata_q << {lane, 3'b000};

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_be  (byte_en(size_q, lane)),
    .addr   (word_idx),
    .wr_dat (wr_word),
    .rd_dat (rd_word)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_BUSY: begin
        if (commit) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || we_q) ? 32'd0 : load_extend(rd_word, size_q, lane, uns_q);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        // IDLE and RESP both accept, so RESP can chain straight into the next access.
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    req_ready_d = (state_d != S_BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl (DEPTH_WORDS=64, LATENCY=2): directed table, corner sequences, random vs byte-array model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH     = 64;
  localparam int LAT       = 2;
  localparam int MEM_BYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_W(32)) bus ();

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] ref_mem [MEM_BYTES];

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic add_vec(input string name, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_er);
    vec_t v;
    v.name = name; v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_er = exp_er;
    vecs.push_back(v);
  endtask

  // Byte-granular memory model: an access touches n consecutive bytes from the aligned base.
  function automatic void model_op(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   output logic [31:0] rd, output logic er);
    int unsigned n;
    int unsigned base;
    logic [31:0] v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || (addr >= 32'(MEM_BYTES));
`ifdef DMEM_ALIGN_CHECK_EN
    if ((addr % n) != 0) er = 1'b1;
`endif
    base = addr - (addr % n);
    rd   = 32'd0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < int'(n); i++) ref_mem[base + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < int'(n); i++) v[8*i +: 8] = ref_mem[base + i];
      if (!uns && n < 4 && v[8*n - 1]) begin
        for (int b = 8 * int'(n); b < 32; b++) v[b] = 1'b1;
      end
      rd = v;
    end
  endfunction

  task automatic drive_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
  endtask

  // edges counts the accept edge as 1; extra is rsp_valid one cycle after the pulse.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int edges, output logic extra);
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    drive_req(we, sz, uns, addr, wd);
    while (!bus.req_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_we    = ~we;
    edges = 1;
    while (!bus.rsp_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    @(posedge clk);
    #1;
    extra = bus.rsp_valid;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer, extra;
    int          edges;

    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_rdata", bus.rsp_rdata, 0);
    check("reset_rsp_err",   bus.rsp_err,   0);
    @(negedge clk);
    rst = 1'b0;

    add_vec("st_w_10",      1, SZ_WORD, 0, 32'h10,       32'hDEADBEEF, 32'h0,        0);
    add_vec("ld_w_10",      0, SZ_WORD, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0);
    add_vec("st_b_21",      1, SZ_BYTE, 0, 32'h21,       32'hFFFFFF80, 32'h0,        0);
    add_vec("ld_bs_21",     0, SZ_BYTE, 0, 32'h21,       32'h0,        32'hFFFFFF80, 0);
    add_vec("ld_bu_21",     0, SZ_BYTE, 1, 32'h21,       32'h0,        32'h00000080, 0);
    add_vec("ld_w_20",      0, SZ_WORD, 0, 32'h20,       32'h0,        32'h00008000, 0);
    add_vec("ld_w_oor",     0, SZ_WORD, 0, 32'h100,      32'h0,        32'h0,        1);
    add_vec("st_w_oor",     1, SZ_WORD, 0, 32'h100,      32'hCAFEF00D, 32'h0,        1);
    add_vec("st_w_nowrap",  1, SZ_WORD, 0, 32'hFFFFFFFC, 32'h11111111, 32'h0,        1);
    add_vec("ld_w_fc",      0, SZ_WORD, 0, 32'hFC,       32'h0,        32'h0,        0);
    add_vec("ld_w_00",      0, SZ_WORD, 0, 32'h00,       32'h0,        32'h0,        0);
    add_vec("ld_w_10_again",0, SZ_WORD, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0);
    add_vec("ld_hs_10",     0, SZ_HALF, 0, 32'h10,       32'h0,        32'hFFFFBEEF, 0);
    add_vec("ld_hu_12",     0, SZ_HALF, 1, 32'h12,       32'h0,        32'h0000DEAD, 0);
    add_vec("ld_sz3",       0, 2'b11,   0, 32'h10,       32'h0,        32'h0,        1);
    add_vec("st_sz3",       1, 2'b11,   0, 32'h10,       32'h0,        32'h0,        1);
    add_vec("ld_w_10_kept", 0, SZ_WORD, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0);
    add_vec("st_h_02",      1, SZ_HALF, 0, 32'h02,       32'h1234A5C3, 32'h0,        0);
`ifdef DMEM_ALIGN_CHECK_EN
    add_vec("ld_hu_03",     0, SZ_HALF, 1, 32'h03,       32'h0,        32'h0,        1);
`else
    add_vec("ld_hu_03",     0, SZ_HALF, 1, 32'h03,       32'h0,        32'h0000A5C3, 0);
`endif
    add_vec("ld_w_00_h",    0, SZ_WORD, 0, 32'h00,       32'h0,        32'hA5C30000, 0);
    add_vec("ld_bs_03",     0, SZ_BYTE, 0, 32'h03,       32'h0,        32'hFFFFFFA5, 0);

    foreach (vecs[k]) begin
      model_op(vecs[k].we, vecs[k].sz, vecs[k].uns, vecs[k].addr, vecs[k].wd, mrd, mer);
      do_req(vecs[k].we, vecs[k].sz, vecs[k].uns, vecs[k].addr, vecs[k].wd, rd, er, edges, extra);
      check({vecs[k].name, "_rdata"},   rd,    vecs[k].exp_rd);
      check({vecs[k].name, "_err"},     er,    vecs[k].exp_er);
      check({vecs[k].name, "_latency"}, edges, 3);
      check({vecs[k].name, "_pulse1"},  extra, 0);
    end

    // Continuous req_valid: four loads accepted back-to-back.
    begin
      logic [31:0] b_addr [4];
      logic [1:0]  b_sz   [4];
      logic        b_uns  [4];
      logic [31:0] exp_rd_q[$];
      logic        exp_er_q[$];
      int          acc, pulses, last_acc, extra_p;
      logic        rdy, prev_rsp, just_acc;
      b_addr[0] = 32'h10;  b_sz[0] = SZ_WORD; b_uns[0] = 0;
      b_addr[1] = 32'h20;  b_sz[1] = SZ_WORD; b_uns[1] = 0;
      b_addr[2] = 32'h21;  b_sz[2] = SZ_BYTE; b_uns[2] = 1;
      b_addr[3] = 32'h100; b_sz[3] = SZ_WORD; b_uns[3] = 0;
      acc = 0; pulses = 0; last_acc = 0; prev_rsp = 1'b0;
      @(negedge clk);
      drive_req(0, b_sz[0], b_uns[0], b_addr[0], 32'h0);
      for (int cyc = 0; cyc < 60 && pulses < 4; cyc++) begin
        rdy = bus.req_ready;
        just_acc = 1'b0;
        @(posedge clk);
        if (rdy && bus.req_valid) begin
          model_op(0, b_sz[acc], b_uns[acc], b_addr[acc], 32'h0, mrd, mer);
          exp_rd_q.push_back(mrd);
          exp_er_q.push_back(mer);
          if (acc > 0) check("b2b_spacing", cyc - last_acc, 3);
          last_acc = cyc;
          acc++;
          just_acc = 1'b1;
        end
        #1;
        if (bus.rsp_valid) begin
          check("b2b_not_merged", prev_rsp, 0);
          if (exp_rd_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL b2b_unexpected_rsp: got a response, expected none");
          end else begin
            check("b2b_rdata", bus.rsp_rdata, exp_rd_q.pop_front());
            check("b2b_err",   bus.rsp_err,   exp_er_q.pop_front());
          end
          pulses++;
        end
        prev_rsp = bus.rsp_valid;
        @(negedge clk);
        if (just_acc) check("b2b_ready_low_busy", bus.req_ready, 0);
        if (acc >= 4) bus.req_valid = 1'b0;
        else drive_req(0, b_sz[acc], b_uns[acc], b_addr[acc], 32'h0);
      end
      extra_p = 0;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (bus.rsp_valid) extra_p++;
      end
      check("b2b_accepts", acc, 4);
      check("b2b_pulses", pulses, 4);
      check("b2b_no_extra", extra_p, 0);
    end

    // Reset one cycle after accepting a store: the store must vanish.
    begin
      int seen;
      @(negedge clk);
      drive_req(1, SZ_WORD, 0, 32'h04, 32'h12345678);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_rsp_valid", bus.rsp_valid, 0);
      check("rst_mid_req_ready", bus.req_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (bus.rsp_valid) seen++;
      end
      check("rst_mid_no_rsp", seen, 0);
      model_op(0, SZ_WORD, 0, 32'h04, 32'h0, mrd, mer);
      do_req(0, SZ_WORD, 0, 32'h04, 32'h0, rd, er, edges, extra);
      check("rst_mid_ld_04", rd, 32'h0);
      check("rst_mid_ld_04_err", er, 0);
    end

    // Random traffic against the byte-array model.
    for (int t = 0; t < 120; t++) begin
      logic        rwe, runs;
      logic [1:0]  rsz;
      logic [31:0] raddr, rwd;
      int          r;
      rwe  = 1'($urandom_range(0, 1));
      runs = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 9);
      rsz  = (r < 3) ? SZ_BYTE : (r < 6) ? SZ_HALF : (r < 9) ? SZ_WORD : 2'b11;
      raddr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES + 15));
      rwd  = $urandom;
      model_op(rwe, rsz, runs, raddr, rwd, mrd, mer);
      do_req(rwe, rsz, runs, raddr, rwd, rd, er, edges, extra);
      check("rand_rdata",   rd,    mrd);
      check("rand_err",     er,    mer);
      check("rand_latency", edges, 3);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
